// File: rtl/uart_rx_stim_tx.sv
// UART transmit stimulus generator: buffers bytes in a FIFO and serializes them as
// 8-bit LSB-first frames with optional parity, optional second stop bit and line break.
module uart_rx_stim_tx #(
  parameter int FifoDepth = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [15:0]                 baud_div_i,
  input  logic                        parity_en_i,
  input  logic                        parity_odd_i,
  input  logic                        two_stop_i,
  input  logic [7:0]                  data_i,
  input  logic                        valid_i,
  output logic                        ready_o,
  input  logic                        break_i,
  output logic                        tx_o,
  output logic                        busy_o,
  output logic [$clog2(FifoDepth):0]  fifo_count_o
);

  localparam int PtrW = $clog2(FifoDepth);
  localparam int CntW = PtrW + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(FifoDepth);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);
  localparam logic [15:0]     MinDiv  = 16'd4;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK, MARK} state_e;

  state_e          state_q, state_d;
  logic [15:0]     div_q, div_d, bit_cnt_q, bit_cnt_d, div_in;
  logic [7:0]      sh_q, sh_d;
  logic [2:0]      idx_q, idx_d;
  logic            par_q, par_d, par_en_q, par_en_d, two_stop_q, two_stop_d;
  logic            tx_q, tx_d;
  logic            load, push, bit_end, fifo_empty;

  logic [7:0]      mem [FifoDepth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;

  assign div_in       = (baud_div_i < MinDiv) ? MinDiv : baud_div_i;
  assign bit_end      = (bit_cnt_q == div_q - 16'd1);
  assign fifo_empty   = (count_q == '0);
  assign ready_o      = (count_q != CntFull);
  assign push         = valid_i && ready_o;
  assign fifo_count_o = count_q;
  assign busy_o       = (state_q != IDLE) || !fifo_empty;
  assign tx_o         = tx_q;

  // NOTE: the storage array has no reset; flushing only needs the pointers and count cleared.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_q] <= data_i;
  end

  // NOTE: every sequential block uses non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (load) rd_ptr_q <= rd_ptr_q + PtrOne;
      case ({push, load})
        2'b10:   count_q <= count_q + CntOne;
        2'b01:   count_q <= count_q - CntOne;
        default: count_q <= count_q;
      endcase
    end
  end

  // State register; tx is registered from the next-state output so the line is glitch-free.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      div_q      <= MinDiv;
      bit_cnt_q  <= '0;
      sh_q       <= '0;
      idx_q      <= '0;
      par_q      <= 1'b0;
      par_en_q   <= 1'b0;
      two_stop_q <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_cnt_q  <= bit_cnt_d;
      sh_q       <= sh_d;
      idx_q      <= idx_d;
      par_q      <= par_d;
      par_en_q   <= par_en_d;
      two_stop_q <= two_stop_d;
      tx_q       <= tx_d;
    end
  end

  // NOTE: every signal written here gets a default first so no latch can be inferred.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bit_cnt_d  = bit_end ? '0 : bit_cnt_q + 16'd1;
    sh_d       = sh_q;
    idx_d      = idx_q;
    par_d      = par_q;
    par_en_d   = par_en_q;
    two_stop_d = two_stop_q;
    load       = 1'b0;

    case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        if (break_i)          state_d = BRK;
        else if (!fifo_empty) load    = 1'b1;
      end
      START: if (bit_end) state_d = DATA;
      DATA: if (bit_end) begin
        sh_d  = {1'b0, sh_q[7:1]};
        par_d = par_q ^ sh_q[0];
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd7) state_d = par_en_q ? PARITY : STOP;
      end
      PARITY: if (bit_end) state_d = STOP;
      STOP: if (bit_end) begin
        if (two_stop_q && idx_q == 3'd0) begin
          idx_d = 3'd1;
        end else begin
          idx_d = 3'd0;
          if (break_i)          state_d = BRK;
          else if (!fifo_empty) load    = 1'b1;
          else                  state_d = IDLE;
        end
      end
      BRK: begin
        bit_cnt_d = '0;
        // The mark period uses the divider in force when break is released.
        if (!break_i) begin
          state_d = MARK;
          div_d   = div_in;
        end
      end
      MARK: if (bit_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (load) begin
      state_d    = START;
      sh_d       = mem[rd_ptr_q];
      div_d      = div_in;
      par_en_d   = parity_en_i;
      two_stop_d = two_stop_i;
      par_d      = parity_odd_i;
      idx_d      = 3'd0;
      bit_cnt_d  = '0;
    end
  end

  always_comb begin
    case (state_d)
      START, BRK: tx_d = 1'b0;
      DATA:       tx_d = sh_d[0];
      PARITY:     tx_d = par_d;
      default:    tx_d = 1'b1;
    endcase
  end

endmodule
